// File: rtl/btb_ctrl_if.sv
// Signal bundle between the BTB control stage, its fetch/EX clients and the 2-way BTB array.
// The master modport is the control stage's view; slave is the surrounding environment.
interface btb_ctrl_if #(
    parameter int TAGW = 27
);
    logic            fetch_valid;
    logic [31:0]     fetch_pc;
    logic            pred_hit;
    logic            pred_taken;
    logic [31:0]     pred_target;
    logic            fetch_stall;

    logic            upd_valid;
    logic            upd_ready;
    logic [31:0]     upd_pc;
    logic            upd_taken;
    logic [31:0]     upd_target;

    logic [2:0]      btb_rd_set;
    logic            btb_rd_valid0;
    logic            btb_rd_valid1;
    logic [TAGW-1:0] btb_rd_tag0;
    logic [TAGW-1:0] btb_rd_tag1;
    logic [31:0]     btb_rd_target0;
    logic [31:0]     btb_rd_target1;
    logic [1:0]      btb_rd_state0;
    logic [1:0]      btb_rd_state1;
    logic            btb_rd_lru;

    logic            btb_wr_en;
    logic [2:0]      btb_wr_set;
    logic            btb_wr_way;
    logic            btb_wr_valid;
    logic [TAGW-1:0] btb_wr_tag;
    logic [31:0]     btb_wr_target;
    logic [1:0]      btb_wr_state;
    logic            btb_wr_lru_en;
    logic            btb_wr_lru_val;

    modport master (
        input  fetch_valid, fetch_pc, upd_valid, upd_pc, upd_taken, upd_target,
        input  btb_rd_valid0, btb_rd_valid1, btb_rd_tag0, btb_rd_tag1,
        input  btb_rd_target0, btb_rd_target1, btb_rd_state0, btb_rd_state1, btb_rd_lru,
        output pred_hit, pred_taken, pred_target, fetch_stall, upd_ready, btb_rd_set,
        output btb_wr_en, btb_wr_set, btb_wr_way, btb_wr_valid, btb_wr_tag,
        output btb_wr_target, btb_wr_state, btb_wr_lru_en, btb_wr_lru_val
    );

    modport slave (
        output fetch_valid, fetch_pc, upd_valid, upd_pc, upd_taken, upd_target,
        output btb_rd_valid0, btb_rd_valid1, btb_rd_tag0, btb_rd_tag1,
        output btb_rd_target0, btb_rd_target1, btb_rd_state0, btb_rd_state1, btb_rd_lru,
        input  pred_hit, pred_taken, pred_target, fetch_stall, upd_ready, btb_rd_set,
        input  btb_wr_en, btb_wr_set, btb_wr_way, btb_wr_valid, btb_wr_tag,
        input  btb_wr_target, btb_wr_state, btb_wr_lru_en, btb_wr_lru_val
    );
endinterface

// File: rtl/btb_ctrl.sv
// BTB control stage: zero-latency fetch lookup plus a queued update path that retires one
// resolved branch per granted cycle as a read-modify-write, stealing the read port when starved.
module btb_ctrl #(
    parameter int TAGW       = 27,
    parameter int FIFO_DEPTH = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic     clk,
    input  logic     rst,
    btb_ctrl_if.master bus
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int SW = $clog2(STARVE_MAX + 1);

    logic [31:0]     q_pc     [FIFO_DEPTH];
    logic            q_taken  [FIFO_DEPTH];
    logic [31:0]     q_target [FIFO_DEPTH];
    logic [PW-1:0]   rd_ptr, wr_ptr;
    logic [CW-1:0]   count;
    logic [SW-1:0]   starve_cnt;

    logic            empty, full, push, grant, look;
    logic [31:0]     head_pc, head_target;
    logic            head_taken;
    logic [TAGW-1:0] fetch_tag, head_tag;
    logic            fhit0, fhit1, uhit0, uhit1;

    function automatic logic [1:0] sat_step(input logic [1:0] s, input logic up);
        if (up)
            return (s == 2'b11) ? s : s + 2'b01;
        return (s == 2'b00) ? s : s - 2'b01;
    endfunction

    assign empty         = (count == '0);
    assign full          = (count == CW'(FIFO_DEPTH));
    assign bus.upd_ready = !full;
    assign push          = bus.upd_valid && !full;
    assign grant         = !empty && (!bus.fetch_valid || starve_cnt == SW'(STARVE_MAX));
    assign look          = bus.fetch_valid && !grant;

    assign head_pc     = q_pc[rd_ptr];
    assign head_taken  = q_taken[rd_ptr];
    assign head_target = q_target[rd_ptr];
    assign fetch_tag   = TAGW'(bus.fetch_pc[31:5]);
    assign head_tag    = TAGW'(head_pc[31:5]);

    assign bus.btb_rd_set  = grant ? head_pc[4:2] : bus.fetch_pc[4:2];
    assign bus.fetch_stall = grant && bus.fetch_valid;

    // Queue storage carries no reset; occupancy is tracked solely by count.
    always_ff @(posedge clk) begin
        if (push) begin
            q_pc[wr_ptr]     <= bus.upd_pc;
            q_taken[wr_ptr]  <= bus.upd_taken;
            q_target[wr_ptr] <= bus.upd_target;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count      <= '0;
            starve_cnt <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (grant)
                rd_ptr <= rd_ptr + 1'b1;
            if (push && !grant)
                count <= count + 1'b1;
            else if (!push && grant)
                count <= count - 1'b1;
            if (empty || grant)
                starve_cnt <= '0;
            else if (bus.fetch_valid)
                starve_cnt <= starve_cnt + 1'b1;
        end
    end

    assign fhit0 = bus.btb_rd_valid0 && (bus.btb_rd_tag0 == fetch_tag);
    assign fhit1 = bus.btb_rd_valid1 && (bus.btb_rd_tag1 == fetch_tag);
    assign uhit0 = bus.btb_rd_valid0 && (bus.btb_rd_tag0 == head_tag);
    assign uhit1 = bus.btb_rd_valid1 && (bus.btb_rd_tag1 == head_tag);

    always_comb begin
        bus.pred_hit    = 1'b0;
        bus.pred_taken  = 1'b0;
        bus.pred_target = '0;
        if (look && fhit0) begin
            bus.pred_hit    = 1'b1;
            bus.pred_taken  = bus.btb_rd_state0[1];
            bus.pred_target = bus.btb_rd_target0;
        end else if (look && fhit1) begin
            bus.pred_hit    = 1'b1;
            bus.pred_taken  = bus.btb_rd_state1[1];
            bus.pred_target = bus.btb_rd_target1;
        end
    end

    always_comb begin
        bus.btb_wr_en      = 1'b0;
        bus.btb_wr_set     = '0;
        bus.btb_wr_way     = 1'b0;
        bus.btb_wr_valid   = 1'b0;
        bus.btb_wr_tag     = '0;
        bus.btb_wr_target  = '0;
        bus.btb_wr_state   = '0;
        bus.btb_wr_lru_en  = 1'b0;
        bus.btb_wr_lru_val = 1'b0;
        if (grant && (uhit0 || uhit1)) begin
            // Way 0 takes priority when both ways carry the same tag.
            bus.btb_wr_en      = 1'b1;
            bus.btb_wr_set     = head_pc[4:2];
            bus.btb_wr_way     = !uhit0;
            bus.btb_wr_valid   = 1'b1;
            bus.btb_wr_tag     = uhit0 ? bus.btb_rd_tag0 : bus.btb_rd_tag1;
            bus.btb_wr_state   = sat_step(uhit0 ? bus.btb_rd_state0 : bus.btb_rd_state1, head_taken);
            bus.btb_wr_target  = head_taken ? head_target
                               : (uhit0 ? bus.btb_rd_target0 : bus.btb_rd_target1);
            bus.btb_wr_lru_en  = 1'b1;
            bus.btb_wr_lru_val = uhit0;
        end else if (grant && head_taken) begin
            bus.btb_wr_en      = 1'b1;
            bus.btb_wr_set     = head_pc[4:2];
            bus.btb_wr_way     = !bus.btb_rd_valid0 ? 1'b0
                               : !bus.btb_rd_valid1 ? 1'b1 : bus.btb_rd_lru;
            bus.btb_wr_valid   = 1'b1;
            bus.btb_wr_tag     = head_tag;
            bus.btb_wr_target  = head_target;
            bus.btb_wr_state   = 2'b10;
            bus.btb_wr_lru_en  = 1'b1;
            bus.btb_wr_lru_val = !bus.btb_wr_way;
        end
    end
endmodule
